booth_wallace_mul_pipe: RTL and testbench
=========================================

// Module: booth_wallace_mul_pipe
// PURPOSE
//   Pipelined radix-4 Booth / Wallace-tree multiplier for the ALU mul path.
//   Accepts one op per cycle under valid/ready flow control.
//   Supports signed and unsigned operands per op and returns the full 2*XLEN product.
//   Replaces the fixed 2-cycle, no-backpressure multiplier.
// PARAMETERS
//   XLEN    32  operand width; must be even and >= 8
//   TAG_W   4   width of user tag carried alongside each op
// PORTS
//   clk        in   1        clock, rising edge
//   resetn     in   1        asynchronous active-low reset
//   in_valid   in   1        op present on src1/src2/in_signed/in_tag
//   in_ready   out  1        block can accept op this cycle
//   src1       in   XLEN     multiplicand
//   src2       in   XLEN     multiplier
//   in_signed  in   1        1: both operands two's complement; 0: both unsigned
//   in_tag     in   TAG_W    opaque tag, returned with result
//   out_valid  out  1        result valid
//   out_ready  in   1        consumer accepts result this cycle
//   result     out  2*XLEN   full product
//   out_tag    out  TAG_W    tag of the op in result
//   flush      in   1        (MUL_FLUSH_EN only) kill all in-flight ops
// BEHAVIOUR
//   - Reset (resetn=0, async): all stage valids=0, out_valid=0, in_ready=0.
//     Data regs are not reset. in_ready rises on the first clk edge after resetn deasserts.
//   - Operand prep: extend both operands to XLEN+2 bits.
//     Sign-extend if in_signed=1, zero-extend if 0.
//     Booth yields (XLEN+2)/2 partial products.
//   - Pipeline has 3 register stages (S1, S2, S3); each stage holds valid, data and tag.
//     S1: registered extended operands, signed flag and tag.
//     S2: Booth encode + Wallace compress to sum/carry vectors (2*XLEN+4 bits) + carry-in bit.
//     S3: final carry-propagate add; result = low 2*XLEN bits.
//   - Latency: exactly 3 cycles from in_valid&&in_ready to out_valid when out_ready stays 1.
//     Throughput: 1 op/cycle.
//   - Flow control: stage k loads when (!valid_k || advance_k+1); advance_out = out_ready.
//     in_ready = !valid_S1 || S1 advancing; combinational from out_ready, no in_valid dependency.
//   - Backpressure: out_valid=1 && out_ready=0 holds result/out_tag stable.
//     Upstream stages fill bubbles, then stall; no op is dropped or duplicated.
//   - Simultaneous accept at input and output in the same cycle is legal.
//     All 3 stages full with out_ready=1 sustains 1 op/cycle.
//   - Ordering: results leave in acceptance order; out_tag identifies each op.
//   - Arithmetic: result is exact mod 2^(2*XLEN) for both modes.
//     Signed: MIN*MIN = +2^(2*XLEN-2).
//     Unsigned: (2^XLEN-1)^2 is correct, with no sign corruption from the extension bits.
//   - src1/src2/in_signed/in_tag are sampled only on accept. Values when in_valid=0 are don't-care.
//   - Async reset mid-operation discards all in-flight ops; no partial result is emitted.
// CONFIGURATION
//   MUL_FLUSH_EN defined:
//     - flush port exists.
//     - flush=1 clears all stage valids at the next edge; out_valid=0 the cycle after.
//     - in_ready=0 while flush=1; an op offered in a flush cycle is not accepted.
//     - flush has priority over any simultaneous accept or advance.
//   MUL_FLUSH_EN undefined:
//     - no flush port; in-flight ops are removed only by resetn.
// TESTING
//   1 signed: src1=0xFFFFFFFF (-1), src2=0x00000007 -> result 0xFFFFFFFF_FFFFFFF9 at cycle +3.
//   2 unsigned: src1=src2=0xFFFFFFFF -> result 0xFFFFFFFE_00000001.
//     signed: 0x80000000*0x80000000 -> 0x40000000_00000000.
//   3 streaming: 100 back-to-back random ops, tags 0..15, out_ready=1.
//     -> 1 result/cycle after 3-cycle fill; tags in order; all products match reference model.
//   4 backpressure: random out_ready (50%) with continuous in_valid.
//     -> no loss or duplication; result stable while stalled; in_ready=0 only when all stages full and stalled.
//   5 reset: assert resetn=0 with 3 ops in flight.
//     -> out_valid=0 immediately (async), no stale result after release; first new op returns in 3 cycles.
//   6 flush (MUL_FLUSH_EN): flush with 2 ops in flight plus one offered in the same cycle.
//     -> none appear; next accepted op returns correctly.

Source files
------------

// File: rtl/booth_wallace_mul_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_wallace_mul_pipe_if
// Purpose  : Operand/result handshake bundle for the pipelined multiplier.
// Revision : 1.0 - initial release
// ============================================================================
interface booth_wallace_mul_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
);
   logic                in_valid;
   logic                in_ready;
   logic [XLEN-1:0]     src1;
   logic [XLEN-1:0]     src2;
   logic                in_signed;
   logic [TAG_W-1:0]    in_tag;
   logic                out_valid;
   logic                out_ready;
   logic [2*XLEN-1:0]   result;
   logic [TAG_W-1:0]    out_tag;

   modport master (
      output in_valid, src1, src2, in_signed, in_tag, out_ready,
      input  in_ready, out_valid, result, out_tag
   );

   modport slave (
      input  in_valid, src1, src2, in_signed, in_tag, out_ready,
      output in_ready, out_valid, result, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/booth_wallace_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : booth_wallace_mul_pipe
// Purpose  : 3-stage radix-4 Booth / Wallace multiplier, valid/ready flow
//            control, signed/unsigned per op. MUL_FLUSH_EN adds a flush port.
// Revision : 1.0 - initial release
// ============================================================================
module booth_wallace_mul_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic clk,
   input  logic resetn,
   booth_wallace_mul_pipe_if.slave bus
`ifdef MUL_FLUSH_EN
   ,
   input  logic flush
`endif
);
   localparam int EXT_W = XLEN + 2;
   localparam int NPP   = EXT_W / 2;
   localparam int PW    = 2 * XLEN + 4;
   localparam int ROWS  = NPP + 1;

   function automatic int rows_at(input int lvl);
      int n;
      n = ROWS;
      for (int i = 0; i < lvl; i++) n = (n / 3) * 2 + (n % 3);
      return n;
   endfunction

   function automatic int csa_levels();
      int n;
      int l;
      n = ROWS;
      l = 0;
      while (n > 2) begin
         n = (n / 3) * 2 + (n % 3);
         l = l + 1;
      end
      return l;
   endfunction

   localparam int LEVELS = csa_levels();

   logic                r_run;
   logic                r_s1_valid;
   logic                r_s2_valid;
   logic                r_s3_valid;
   logic [XLEN-1:0]     r_s1_a;
   logic [XLEN-1:0]     r_s1_b;
   logic                r_s1_sgn;
   logic [TAG_W-1:0]    r_s1_tag;
   logic [PW-1:0]       r_s2_sum;
   logic [PW-1:0]       r_s2_carry;
   logic                r_s2_cin;
   logic [TAG_W-1:0]    r_s2_tag;
   logic [2*XLEN-1:0]   r_s3_result;
   logic [TAG_W-1:0]    r_s3_tag;

   logic                w_flush;
   logic                w_load1;
   logic                w_load2;
   logic                w_load3;
   logic                w_in_ready;
   logic                w_accept;
   logic [EXT_W-1:0]    w_a_ext;
   logic [EXT_W-1:0]    w_b_ext;
   logic [PW-1:0]       w_a_pp;
   logic [EXT_W:0]      w_b_pad;
   logic [NPP-1:0]      w_neg;
   logic [PW-1:0]       w_corr;
   logic [PW-1:0]       w_lvl [LEVELS+1][ROWS];
   logic [PW-1:0]       w_s3_full;
   logic                w_unused_hi;

`ifdef MUL_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   // Each stage may load when empty or when the stage below is moving on.
   assign w_load3    = !r_s3_valid || bus.out_ready;
   assign w_load2    = !r_s2_valid || w_load3;
   assign w_load1    = !r_s1_valid || w_load2;
   assign w_in_ready = r_run && w_load1 && !w_flush;
   assign w_accept   = bus.in_valid && w_in_ready;

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s3_valid;
   assign bus.result    = r_s3_result;
   assign bus.out_tag   = r_s3_tag;

   // Two extension bits keep unsigned operands positive in the signed Booth array.
   assign w_a_ext = {{2{r_s1_sgn & r_s1_a[XLEN-1]}}, r_s1_a};
   assign w_b_ext = {{2{r_s1_sgn & r_s1_b[XLEN-1]}}, r_s1_b};
   assign w_a_pp  = {{(PW-EXT_W){w_a_ext[EXT_W-1]}}, w_a_ext};
   assign w_b_pad = {w_b_ext, 1'b0};

   for (genvar j = 0; j < NPP; j++) begin : g_pp
      logic [2:0]    grp;
      logic          one;
      logic          two;
      logic          neg;
      logic [PW-1:0] mag;
      assign grp = w_b_pad[2*j+2 : 2*j];
      assign one = grp[0] ^ grp[1];
      assign two = (grp[2] & ~grp[1] & ~grp[0]) | (~grp[2] & grp[1] & grp[0]);
      assign neg = grp[2] & ~(grp[1] & grp[0]);
      assign mag = one ? w_a_pp : (two ? {w_a_pp[PW-2:0], 1'b0} : '0);
      // Negation is ones-complement here; the +1 lands in w_corr / carry-in.
      assign w_lvl[0][j] = (neg ? ~mag : mag) << (2 * j);
      assign w_neg[j]    = neg;
   end

   for (genvar k = 0; k < PW; k++) begin : g_corr
      if ((k % 2 == 0) && (k > 0) && (k / 2 < NPP)) begin : g_bit
         assign w_corr[k] = w_neg[k/2];
      end else begin : g_zero
         assign w_corr[k] = 1'b0;
      end
   end
   assign w_lvl[0][NPP] = w_corr;

   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int N_IN  = rows_at(l);
      localparam int N_GRP = N_IN / 3;
      localparam int N_OUT = rows_at(l + 1);
      for (genvar g = 0; g < N_GRP; g++) begin : g_csa
         logic [PW-1:0] x;
         logic [PW-1:0] y;
         logic [PW-1:0] z;
         assign x = w_lvl[l][3*g];
         assign y = w_lvl[l][3*g+1];
         assign z = w_lvl[l][3*g+2];
         assign w_lvl[l+1][2*g]   = x ^ y ^ z;
         assign w_lvl[l+1][2*g+1] = ((x & y) | (x & z) | (y & z)) << 1;
      end
      for (genvar r = 3 * N_GRP; r < N_IN; r++) begin : g_pass
         assign w_lvl[l+1][2*N_GRP + r - 3*N_GRP] = w_lvl[l][r];
      end
      for (genvar r = N_OUT; r < ROWS; r++) begin : g_fill
         assign w_lvl[l+1][r] = '0;
      end
   end

   assign w_s3_full   = r_s2_sum + r_s2_carry + {{(PW-1){1'b0}}, r_s2_cin};
   assign w_unused_hi = ^w_s3_full[PW-1:2*XLEN];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_run      <= 1'b0;
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_s3_valid <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (w_flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
         end else begin
            if (w_load1) r_s1_valid <= w_accept;
            if (w_load2) r_s2_valid <= r_s1_valid;
            if (w_load3) r_s3_valid <= r_s2_valid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_a   <= bus.src1;
         r_s1_b   <= bus.src2;
         r_s1_sgn <= bus.in_signed;
         r_s1_tag <= bus.in_tag;
      end
      if (w_load2 && r_s1_valid) begin
         r_s2_sum   <= w_lvl[LEVELS][0];
         r_s2_carry <= w_lvl[LEVELS][1];
         r_s2_cin   <= w_neg[0];
         r_s2_tag   <= r_s1_tag;
      end
      if (w_load3 && r_s2_valid) begin
         r_s3_result <= w_s3_full[2*XLEN-1:0];
         r_s3_tag    <= r_s2_tag;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_booth_wallace_mul_pipe.sv
`default_nettype none
// Scoreboard bench for booth_wallace_mul_pipe: random ops vs. an arithmetic model.
module tb_booth_wallace_mul_pipe;
   localparam int XLEN  = 32;
   localparam int TAG_W = 4;

   typedef struct {
      logic [63:0] res;
      logic [3:0]  tag;
      int          cyc;
      bit          lat;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic flush_s = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   chk_rdy = 1'b0;
   bit   lat_mode = 1'b0;
   bit   bp_mode = 1'b0;
   bit   stall_prev = 1'b0;
   logic [63:0] hold_res;
   logic [3:0]  hold_tag;
   exp_t q[$];

   booth_wallace_mul_pipe_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   booth_wallace_mul_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
`ifdef MUL_FLUSH_EN
      ,
      .flush  (flush_s)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint pa;
      longint pb;
      if (s) begin
         pa = $signed(a);
         pb = $signed(b);
      end else begin
         pa = {32'd0, a};
         pb = {32'd0, b};
      end
      return 64'(pa * pb);
   endfunction

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic monitor_step();
      exp_t e;
      if (!resetn) begin
         stall_prev = 1'b0;
         return;
      end
      if (chk_rdy)
         check("in_ready", 64'(bus.in_ready), 64'(!(q.size() == 3 && !bus.out_ready)));
      if (stall_prev) begin
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_result", bus.result, hold_res);
         check("hold_tag", 64'(bus.out_tag), 64'(hold_tag));
      end
      if (bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_output", 64'(bus.out_tag), 64'hDEAD);
         end else begin
            e = q.pop_front();
            check("result", bus.result, e.res);
            check("tag", 64'(bus.out_tag), 64'(e.tag));
            if (e.lat) check("latency", 64'(cyc - e.cyc), 64'd3);
         end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      hold_res   = bus.result;
      hold_tag   = bus.out_tag;
      if (bus.in_valid && bus.in_ready) begin
         e.res = ref_mul(bus.src1, bus.src2, bus.in_signed);
         e.tag = bus.in_tag;
         e.cyc = cyc;
         e.lat = lat_mode;
         q.push_back(e);
      end
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [3:0] t);
      bit acc;
      acc = 1'b0;
      bus.src1 = a;
      bus.src2 = b;
      bus.in_signed = s;
      bus.in_tag = t;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
      bus.in_valid = 1'b0;
      bus.src1 = $urandom;
      bus.src2 = $urandom;
      bus.in_tag = 4'($urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 500; i++) begin
         if (q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.src1 = '0;
      bus.src2 = '0;
      bus.in_signed = 1'b0;
      bus.in_tag = '0;
      bus.out_ready = 1'b1;

      fork
         forever begin
            @(negedge clk);
            monitor_step();
         end
         forever begin
            @(posedge clk);
            #1;
            if (bp_mode) bus.out_ready = 1'($urandom_range(0, 1));
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_in_ready", 64'(bus.in_ready), 64'd0);
      #2 resetn = 1'b1;
      check("ready_before_edge", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("ready_after_edge", 64'(bus.in_ready), 64'd1);
      chk_rdy = 1'b1;

      // Directed corner products, fixed 3-cycle latency.
      lat_mode = 1'b1;
      send(32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 4'd1);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd2);
      send(32'h8000_0000, 32'h8000_0000, 1'b1, 4'd3);
      send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd4);
      send(32'h8000_0000, 32'h8000_0000, 1'b0, 4'd5);
      send(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 4'd6);
      drain();

      // Back-to-back random stream.
      for (int i = 0; i < 100; i++) send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 4'(i));
      drain();
      lat_mode = 1'b0;

      // Random backpressure.
      bp_mode = 1'b1;
      for (int i = 0; i < 150; i++) send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 4'(i));
      drain();
      bp_mode = 1'b0;
      bus.out_ready = 1'b1;
      drain();

      // Asynchronous reset with three ops in flight.
      send($urandom, $urandom, 1'b1, 4'd7);
      send($urandom, $urandom, 1'b0, 4'd8);
      send($urandom, $urandom, 1'b1, 4'd9);
      chk_rdy = 1'b0;
      resetn = 1'b0;
      #1;
      check("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("async_reset_in_ready", 64'(bus.in_ready), 64'd0);
      q.delete();
      repeat (2) @(posedge clk);
      #2 resetn = 1'b1;
      check("rerelease_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      check("rerelease_ready_edge", 64'(bus.in_ready), 64'd1);
      chk_rdy = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      lat_mode = 1'b1;
      send(32'h1234_5678, 32'hFEDC_BA98, 1'b1, 4'd10);
      drain();
      lat_mode = 1'b0;

`ifdef MUL_FLUSH_EN
      // Flush with two ops in flight and a third offered in the same cycle.
      send($urandom, $urandom, 1'b0, 4'd11);
      send($urandom, $urandom, 1'b1, 4'd12);
      chk_rdy = 1'b0;
      flush_s = 1'b1;
      bus.src1 = $urandom;
      bus.src2 = $urandom;
      bus.in_tag = 4'd13;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("flush_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      flush_s = 1'b0;
      bus.in_valid = 1'b0;
      q.delete();
      check("flush_out_valid", 64'(bus.out_valid), 64'd0);
      chk_rdy = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      lat_mode = 1'b1;
      send(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 4'd14);
      drain();
      lat_mode = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire
